// File: rtl/flipper_if.sv
// Frame-rate control inputs and position/speed outputs of the flipper paddle.
interface flipper_if;
  logic               startOfFrame;
  logic               keyLeftIsPressed;
  logic               keyRightIsPressed;
  logic               pause;
  logic               reset_level;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic signed [31:0] flipperSpeedX;

  modport master (
    output startOfFrame, keyLeftIsPressed, keyRightIsPressed, pause, reset_level,
    input  topLeftX, topLeftY, flipperSpeedX
  );

  modport slave (
    input  startOfFrame, keyLeftIsPressed, keyRightIsPressed, pause, reset_level,
    output topLeftX, topLeftY, flipperSpeedX
  );
endinterface

// File: rtl/flipper_controller.sv
// Horizontal flipper paddle: key-driven acceleration, friction coasting and wall clamping,
// updated once per video frame in sub-pixel fixed point.
module flipper_controller #(
  parameter int InitialX             = 260,
  parameter int InitialY             = 440,
  parameter int FlipperWidth         = 100,
  parameter int Accel                = 8,
  parameter int Friction             = 4,
  parameter int MaxSpeed             = 256,
  parameter int FixedPointMultiplier = 64
) (
  input  logic     clk,
  input  logic     resetN,
  flipper_if.slave bus
);

  localparam logic [1:0] StCoast     = 2'd0;
  localparam logic [1:0] StPushLeft  = 2'd1;
  localparam logic [1:0] StPushRight = 2'd2;

  localparam logic signed [31:0] InitPos    = 32'(InitialX * FixedPointMultiplier);
  localparam logic signed [31:0] RightLimit = 32'((639 - FlipperWidth) * FixedPointMultiplier);
  localparam logic signed [31:0] AccelS     = 32'(Accel);
  localparam logic signed [31:0] FrictionS  = 32'(Friction);
  localparam logic signed [31:0] MaxSpeedS  = 32'(MaxSpeed);

  logic [1:0]         state_q, state_d;
  logic signed [31:0] pos_q, pos_d;
  logic signed [31:0] speed_q, speed_d;
  logic signed [31:0] pos_next, speed_next;

  // Frame step: position moves by the old speed, speed reacts to the registered state.
  always_comb begin
    pos_next   = pos_q + speed_q;
    speed_next = speed_q;
    case (state_q)
      StPushRight: speed_next = (speed_q + AccelS > MaxSpeedS) ? MaxSpeedS : speed_q + AccelS;
      StPushLeft:  speed_next = (speed_q - AccelS < -MaxSpeedS) ? -MaxSpeedS : speed_q - AccelS;
      default: begin
        if (speed_q <= FrictionS && speed_q >= -FrictionS) begin
          speed_next = '0;
        end else if (speed_q > 0) begin
          speed_next = speed_q - FrictionS;
        end else begin
          speed_next = speed_q + FrictionS;
        end
      end
    endcase
    if (pos_next < 0) begin
      pos_next   = '0;
      speed_next = '0;
    end else if (pos_next > RightLimit) begin
      pos_next   = RightLimit;
      speed_next = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    speed_d = speed_q;
    if (bus.reset_level) begin
      state_d = StCoast;
      pos_d   = InitPos;
      speed_d = '0;
    end else if (!bus.pause) begin
      if (bus.keyLeftIsPressed && !bus.keyRightIsPressed) begin
        state_d = StPushLeft;
      end else if (bus.keyRightIsPressed && !bus.keyLeftIsPressed) begin
        state_d = StPushRight;
      end else begin
        state_d = StCoast;
      end
      if (bus.startOfFrame) begin
        pos_d   = pos_next;
        speed_d = speed_next;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= StCoast;
      pos_q   <= InitPos;
      speed_q <= '0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      speed_q <= speed_d;
    end
  end

  // Position is never negative, so the division is an exact floor.
  assign bus.topLeftX      = 11'(pos_q / FixedPointMultiplier);
  assign bus.topLeftY      = 11'(InitialY);
  assign bus.flipperSpeedX = speed_q;

endmodule
